change_dispenser: RTL and testbench

- Payout side of the vending datapath: accepts a change amount (rupees) from the vending controller and drives the coin hopper to dispense ten- and five-rupee coins.
- Greedy payout: tens first, then fives.
- Tracks per-denomination coin stock, supports refill, and reports completion or a fault code.
- One coin per hopper handshake; a jammed hopper is detected by a timeout.

---
 rtl/change_dispenser_pkg.sv | 34 +++
 rtl/change_dispenser_if.sv | 41 ++++
 rtl/change_dispenser_coin_stock.sv | 30 +++
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared types and constants for the vending payout datapath
// Purpose: payout FSM state encoding, fault codes, coin values and product costs
// shared by the change dispenser and the vending controller.
package change_dispenser_pkg;

  localparam int AMOUNT_W_DEF = 5;
  localparam int STOCK_W_DEF  = 5;
  localparam int TIMEOUT_DEF  = 15;

  localparam int COIN_TEN  = 10;
  localparam int COIN_FIVE = 5;

  // Product prices used by the vending controller side.
  localparam int COST_TEA    = 10;
  localparam int COST_COFFEE = 15;
  localparam int COST_SODA   = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PAY_TEN,
    ST_PAY_FIVE,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_ALIGN = 2'b01,
    FAULT_STOCK = 2'b10,
    FAULT_JAM   = 2'b11
  } fault_code_t;

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, refill, hopper and status bundle of the change dispenser
// Purpose: groups every non-clock signal of the dispenser.
// master: vending controller / hopper side (drives req, refill, hopper_ack).
// slave : change_dispenser (drives req_ready, coin_*, done, fault, status).
interface change_dispenser_if
  import change_dispenser_pkg::*;
#(
  parameter int AMOUNT_W = AMOUNT_W_DEF,
  parameter int STOCK_W  = STOCK_W_DEF
);

  logic                req_valid;
  logic [AMOUNT_W-1:0] req_amount;
  logic                req_ready;
  logic                refill_ten;
  logic                refill_five;
  logic [STOCK_W-1:0]  refill_count;
  logic                coin_ten;
  logic                coin_five;
  logic                hopper_ack;
  logic                done;
  logic                fault;
  logic [1:0]          fault_code;
  logic [AMOUNT_W-1:0] paid_amount;
  logic [STOCK_W-1:0]  ten_stock;
  logic [STOCK_W-1:0]  five_stock;
  logic                busy;

  modport master (
    output req_valid, req_amount, refill_ten, refill_five, refill_count, hopper_ack,
    input  req_ready, coin_ten, coin_five, done, fault, fault_code, paid_amount,
           ten_stock, five_stock, busy
  );

  modport slave (
    input  req_valid, req_amount, refill_ten, refill_five, refill_count, hopper_ack,
    output req_ready, coin_ten, coin_five, done, fault, fault_code, paid_amount,
           ten_stock, five_stock, busy
  );

endinterface

// File: rtl/change_dispenser_coin_stock.sv
// rtl/change_dispenser_coin_stock.sv - saturating coin stock counter for one denomination
// Purpose: holds the coin count of one hopper tube.
// Ports: clk, reset (async, active high), add_en/add_count (refill, saturating),
// dec_en (one coin ejected), count (current stock).
module coin_stock_counter #(
  parameter int STOCK_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               add_en,
  input  logic [STOCK_W-1:0] add_count,
  input  logic               dec_en,
  output logic [STOCK_W-1:0] count
);

  logic [STOCK_W:0] sum;

  assign sum = {1'b0, count} + {1'b0, add_count};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (add_en) begin
      count <= sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    end else if (dec_en && (count != '0)) begin
      count <= count - STOCK_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy ten/five rupee change payout controller
// Purpose: accepts a change amount, plans tens-then-fives against the coin stock,
// drives the hopper one coin per handshake and reports done or a fault code.
// Ports: clk, reset (async, active high), bus (change_dispenser_if.slave):
// req_* request handshake, refill_* stock refill, coin_*/hopper_ack hopper
// handshake, done/fault/fault_code/paid_amount result, ten/five_stock, busy.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMOUNT_W = AMOUNT_W_DEF,
  parameter int STOCK_W  = STOCK_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus
);

  // Planning width wide enough for both the amount and a stock count.
  localparam int CW = ((AMOUNT_W > STOCK_W) ? AMOUNT_W : STOCK_W) + 1;

  state_t              state;
  fault_code_t         code_q;
  logic [CW-1:0]       remaining;
  logic [CW-1:0]       tens_left;
  logic [CW-1:0]       fives_left;
  logic [AMOUNT_W-1:0] paid_q;
  logic [7:0]          timer;
  logic                coin_ten_q;
  logic                coin_five_q;
  logic                done_q;
  logic                fault_q;
  logic [STOCK_W-1:0]  ten_stock;
  logic [STOCK_W-1:0]  five_stock;

  logic [CW-1:0] tens_cap;
  logic [CW-1:0] tens_plan;
  logic [CW-1:0] fives_plan;
  logic          misaligned;
  logic          ack_ten;
  logic          ack_five;

  // Greedy plan: as many tens as both the amount and the stock allow, fives for the rest.
  always_comb begin
    tens_cap   = remaining / CW'(COIN_TEN);
    tens_plan  = (tens_cap < CW'(ten_stock)) ? tens_cap : CW'(ten_stock);
    fives_plan = (remaining - tens_plan * CW'(COIN_TEN)) / CW'(COIN_FIVE);
    misaligned = (remaining % CW'(COIN_FIVE)) != '0;
  end

  // An ack only counts while the matching coin request is actually raised.
  assign ack_ten  = (state == ST_PAY_TEN)  && coin_ten_q  && bus.hopper_ack;
  assign ack_five = (state == ST_PAY_FIVE) && coin_five_q && bus.hopper_ack;

  coin_stock_counter #(.STOCK_W(STOCK_W)) u_ten_stock (
    .clk       (clk),
    .reset     (reset),
    .add_en    ((state == ST_IDLE) && bus.refill_ten),
    .add_count (bus.refill_count),
    .dec_en    (ack_ten),
    .count     (ten_stock)
  );

  coin_stock_counter #(.STOCK_W(STOCK_W)) u_five_stock (
    .clk       (clk),
    .reset     (reset),
    .add_en    ((state == ST_IDLE) && bus.refill_five),
    .add_count (bus.refill_count),
    .dec_en    (ack_five),
    .count     (five_stock)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      code_q      <= FAULT_NONE;
      remaining   <= '0;
      tens_left   <= '0;
      fives_left  <= '0;
      paid_q      <= '0;
      timer       <= '0;
      coin_ten_q  <= 1'b0;
      coin_five_q <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            remaining <= CW'(bus.req_amount);
            paid_q    <= '0;
            code_q    <= FAULT_NONE;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          tens_left  <= tens_plan;
          fives_left <= fives_plan;
          timer      <= '0;
          if (misaligned) begin
            code_q  <= FAULT_ALIGN;
            fault_q <= 1'b1;
            state   <= ST_FAULT;
          end else if (fives_plan > CW'(five_stock)) begin
            code_q  <= FAULT_STOCK;
            fault_q <= 1'b1;
            state   <= ST_FAULT;
          end else if (remaining == '0) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (tens_plan != '0) begin
            coin_ten_q <= 1'b1;
            state      <= ST_PAY_TEN;
          end else begin
            coin_five_q <= 1'b1;
            state       <= ST_PAY_FIVE;
          end
        end
        ST_PAY_TEN: begin
          if (!coin_ten_q) begin
            coin_ten_q <= 1'b1;  // gap cycle after an ack is over
          end else if (bus.hopper_ack) begin
            coin_ten_q <= 1'b0;
            timer      <= '0;
            tens_left  <= tens_left - CW'(1);
            paid_q     <= paid_q + AMOUNT_W'(COIN_TEN);
            if (tens_left == CW'(1)) begin
              if (fives_left != '0) begin
                state <= ST_PAY_FIVE;
              end else begin
                done_q <= 1'b1;
                state  <= ST_DONE;
              end
            end
          end else if (timer == 8'(TIMEOUT - 1)) begin
            coin_ten_q <= 1'b0;
            code_q     <= FAULT_JAM;
            fault_q    <= 1'b1;
            state      <= ST_FAULT;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_PAY_FIVE: begin
          if (!coin_five_q) begin
            coin_five_q <= 1'b1;
          end else if (bus.hopper_ack) begin
            coin_five_q <= 1'b0;
            timer       <= '0;
            fives_left  <= fives_left - CW'(1);
            paid_q      <= paid_q + AMOUNT_W'(COIN_FIVE);
            if (fives_left == CW'(1)) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end else if (timer == 8'(TIMEOUT - 1)) begin
            coin_five_q <= 1'b0;
            code_q      <= FAULT_JAM;
            fault_q     <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.coin_ten    = coin_ten_q;
  assign bus.coin_five   = coin_five_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.paid_amount = paid_q;
  assign bus.ten_stock   = ten_stock;
  assign bus.five_stock  = five_stock;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int MAXS = 31;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   m_ten = 0;
  int   m_five = 0;

  change_dispenser_if bus();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int s, input int c);
    return (s + c > MAXS) ? MAXS : s + c;
  endfunction

  task automatic refill(input bit ten, input bit five, input int cnt);
    bus.refill_ten   = ten;
    bus.refill_five  = five;
    bus.refill_count = 5'(cnt);
    tick();
    bus.refill_ten  = 1'b0;
    bus.refill_five = 1'b0;
    if (ten)  m_ten  = sat_add(m_ten, cnt);
    if (five) m_five = sat_add(m_five, cnt);
    check("refill.ten_stock", bus.ten_stock, m_ten);
    check("refill.five_stock", bus.five_stock, m_five);
  endtask

  // jam_after < 0: hopper always acks; otherwise it acks that many coins then stalls.
  task automatic request(input string tag, input int amt, input int jam_after, input bit refill_busy);
    int  tens, fives, exp_code, n_coins, exp_t, exp_f, exp_paid;
    int  cyc, acks, t_acked, f_acked, wait_c, delay, jam_high, end_cyc, got_code, got_paid;
    bit  finished, saw_coin, saw_both, order_bad, saw_done, saw_fault;
    tens = amt / COIN_TEN;
    if (tens > m_ten) tens = m_ten;
    fives = (amt - COIN_TEN * tens) / COIN_FIVE;
    if (amt % COIN_FIVE != 0) begin
      exp_code = 1; n_coins = 0;
    end else if (fives > m_five) begin
      exp_code = 2; n_coins = 0;
    end else if (jam_after >= 0 && jam_after < tens + fives) begin
      exp_code = 3; n_coins = jam_after;
    end else begin
      exp_code = 0; n_coins = tens + fives;
    end
    exp_t    = (n_coins < tens) ? n_coins : tens;
    exp_f    = n_coins - exp_t;
    exp_paid = COIN_TEN * exp_t + COIN_FIVE * exp_f;

    check($sformatf("%s.ready", tag), bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = 5'(amt);
    cyc = 0; acks = 0; t_acked = 0; f_acked = 0; wait_c = 0; jam_high = 0;
    end_cyc = 0; got_code = 0; got_paid = 0;
    finished = 0; saw_coin = 0; saw_both = 0; order_bad = 0; saw_done = 0; saw_fault = 0;
    delay = $urandom_range(0, 3);
    while (!finished && cyc < 300) begin
      tick();
      cyc++;
      bus.req_valid  = 1'b0;
      bus.hopper_ack = 1'b0;
      if (refill_busy) begin
        bus.refill_five  = 1'b1;
        bus.refill_count = 5'd1;
      end
      if (cyc == 1) check($sformatf("%s.busy", tag), bus.busy, 1);
      if (bus.coin_ten && bus.coin_five) saw_both = 1;
      if (bus.coin_ten || bus.coin_five) saw_coin = 1;
      if (bus.done || bus.fault) begin
        finished  = 1;
        end_cyc   = cyc;
        saw_done  = bus.done;
        saw_fault = bus.fault;
        got_code  = int'(bus.fault_code);
        got_paid  = int'(bus.paid_amount);
        bus.refill_five = 1'b0;
      end else if (bus.coin_ten || bus.coin_five) begin
        if (jam_after >= 0 && acks >= jam_after) begin
          jam_high++;
        end else if (wait_c >= delay) begin
          bus.hopper_ack = 1'b1;
          acks++;
          if (bus.coin_ten) begin
            t_acked++;
            if (f_acked > 0) order_bad = 1;
          end else begin
            f_acked++;
          end
          wait_c = 0;
          delay  = $urandom_range(0, 3);
        end else begin
          wait_c++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.hopper_ack = 1'b1;  // stray ack with no coin requested
      end
    end
    bus.refill_five = 1'b0;
    bus.hopper_ack  = 1'b0;

    check($sformatf("%s.finished", tag), finished, 1);
    check($sformatf("%s.done", tag), saw_done, (exp_code == 0) ? 1 : 0);
    check($sformatf("%s.fault", tag), saw_fault, (exp_code != 0) ? 1 : 0);
    check($sformatf("%s.code", tag), got_code, exp_code);
    check($sformatf("%s.paid", tag), got_paid, exp_paid);
    check($sformatf("%s.tens", tag), t_acked, exp_t);
    check($sformatf("%s.fives", tag), f_acked, exp_f);
    check($sformatf("%s.both_coins", tag), saw_both, 0);
    check($sformatf("%s.order", tag), order_bad, 0);
    if (exp_code == 1 || exp_code == 2 || amt == 0) begin
      check($sformatf("%s.coin_seen", tag), saw_coin, 0);
      check($sformatf("%s.latency", tag), end_cyc, 2);
    end
    if (exp_code == 3) check($sformatf("%s.jam_cycles", tag), jam_high, TIMEOUT_DEF);

    m_ten  = m_ten - exp_t;
    m_five = m_five - exp_f;
    tick();
    check($sformatf("%s.idle_ready", tag), bus.req_ready, 1);
    check($sformatf("%s.idle_busy", tag), bus.busy, 0);
    check($sformatf("%s.held_code", tag), bus.fault_code, exp_code);
    check($sformatf("%s.held_paid", tag), bus.paid_amount, exp_paid);
    check($sformatf("%s.ten_stock", tag), bus.ten_stock, m_ten);
    check($sformatf("%s.five_stock", tag), bus.five_stock, m_five);
  endtask

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_amount   = '0;
    bus.refill_ten   = 1'b0;
    bus.refill_five  = 1'b0;
    bus.refill_count = '0;
    bus.hopper_ack   = 1'b0;
    repeat (2) tick();
    check("rst.req_ready", bus.req_ready, 1);
    check("rst.busy", bus.busy, 0);
    check("rst.coin_ten", bus.coin_ten, 0);
    check("rst.coin_five", bus.coin_five, 0);
    check("rst.done", bus.done, 0);
    check("rst.fault", bus.fault, 0);
    check("rst.fault_code", bus.fault_code, 0);
    check("rst.paid", bus.paid_amount, 0);
    check("rst.ten_stock", bus.ten_stock, 0);
    check("rst.five_stock", bus.five_stock, 0);
    reset = 1'b0;
    tick();

    // Greedy payout 25 = 10 + 10 + 5.
    refill(1, 1, 3);
    request("pay25", 25, -1, 0);
    // Drain the last ten, then 15 needs three fives with only two in stock.
    request("pay10", 10, -1, 0);
    request("stock_short", 15, -1, 0);
    request("align7", 7, -1, 0);
    // Empty the fives, load two tens, then jam on the second ten.
    request("fives10", 10, -1, 0);
    refill(1, 0, 2);
    request("jam20", 20, 1, 0);
    // Saturation and refill-while-busy.
    refill(0, 1, 30);
    refill(0, 1, 5);
    check("sat.five_stock", bus.five_stock, 31);
    request("zero", 0, -1, 1);
    request("pay5_refill_busy", 5, -1, 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        refill(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 31));
      request($sformatf("rnd%0d", i), $urandom_range(0, 31),
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1, 0);
    end

    // Reset in the middle of a ten-rupee ejection.
    refill(1, 0, 2);
    bus.req_valid  = 1'b1;
    bus.req_amount = 5'd20;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("midrst.coin_before", bus.coin_ten, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst.coin_ten", bus.coin_ten, 0);
    check("midrst.ten_stock", bus.ten_stock, 0);
    check("midrst.five_stock", bus.five_stock, 0);
    check("midrst.req_ready", bus.req_ready, 1);
    check("midrst.paid", bus.paid_amount, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
